// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: RV32I opcodes, bubble values for
// every control field, and the x0 register index.
package id_ex_stage_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [4:0] REG_X0 = 5'd0;

    // A bubble must look like a harmless non-JALR instruction to EX.
    localparam logic       BUB_REGWRITE = 1'b0;
    localparam logic       BUB_MEMWRITE = 1'b0;
    localparam logic       BUB_PCBRANCH = 1'b0;
    localparam logic       BUB_MEMTOREG = 1'b0;
    localparam logic       BUB_JALRCTRL = 1'b1;
    localparam logic [3:0] BUB_ALUOP    = 4'd0;
    localparam logic [2:0] BUB_STRCTRL  = 3'd0;
    localparam logic [1:0] BUB_SRCSEL   = 2'd0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: D-side fields in, registered E-side fields and
// hazard controls out. The stage uses the slave modport.
interface id_ex_stage_if #(
    parameter int XLEN = 32
);
    logic            RegWriteD, MemWriteD, PCBranchD, MemtoRegD, JALRctrlD;
    logic [3:0]      ALUopD;
    logic [2:0]      strCtrlD;
    logic [1:0]      SrcASelD, SrcBSelD;
    logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
    logic [4:0]      Rs1D, Rs2D, RdD;
    logic            validD;
    logic            flush_e;

    logic            RegWriteE, MemWriteE, PCBranchE, MemtoRegE, JALRctrlE;
    logic [3:0]      ALUopE;
    logic [2:0]      strCtrlE;
    logic [1:0]      SrcASelE, SrcBSelE;
    logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]      Rs1E, Rs2E, RdE;
    logic            validE;
    logic            stall_f, stall_d, flush_d;

    modport master (
        output RegWriteD, MemWriteD, PCBranchD, MemtoRegD, JALRctrlD, ALUopD, strCtrlD,
               SrcASelD, SrcBSelD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD,
               validD, flush_e,
        input  RegWriteE, MemWriteE, PCBranchE, MemtoRegE, JALRctrlE, ALUopE, strCtrlE,
               SrcASelE, SrcBSelE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE,
               validE, stall_f, stall_d, flush_d
    );

    modport slave (
        input  RegWriteD, MemWriteD, PCBranchD, MemtoRegD, JALRctrlD, ALUopD, strCtrlD,
               SrcASelD, SrcBSelD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD,
               validD, flush_e,
        output RegWriteE, MemWriteE, PCBranchE, MemtoRegE, JALRctrlE, ALUopE, strCtrlE,
               SrcASelE, SrcBSelE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE,
               validE, stall_f, stall_d, flush_d
    );

endinterface

// File: rtl/id_ex_stage_hazard_lu.sv
// Load-use hazard detection against the instruction currently held in EX.
// Rs fields are compared for every opcode, so LUI/JAL/AUIPC may stall spuriously.
module hazard_lu
    import id_ex_stage_pkg::*;
(
    input  logic       i_valid_e,
    input  logic       i_memtoreg_e,
    input  logic [4:0] i_rd_e,
    input  logic [4:0] i_rs1_d,
    input  logic [4:0] i_rs2_d,
    input  logic       i_valid_d,
    input  logic       i_flush_e,
    output logic       o_lu_haz,
    output logic       o_stall_f,
    output logic       o_stall_d,
    output logic       o_flush_d
);

    logic w_rs_match;

    assign w_rs_match = (i_rd_e == i_rs1_d) | (i_rd_e == i_rs2_d);

    // A flush discards the ID instruction anyway, so it suppresses the stall.
    assign o_lu_haz  = i_valid_e & i_memtoreg_e & (i_rd_e != REG_X0) & w_rs_match
                     & i_valid_d & ~i_flush_e;
    assign o_stall_f = o_lu_haz;
    assign o_stall_d = o_lu_haz;
    assign o_flush_d = i_flush_e;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and branch squash.
// Optional perf counters (bubble_cnt, flush_cnt) when IDEX_PERF_CNT_EN is defined.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
)(
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    typedef struct packed {
        logic            reg_write;
        logic            mem_write;
        logic            pc_branch;
        logic            memtoreg;
        logic            jalr_ctrl;
        logic [3:0]      alu_op;
        logic [2:0]      str_ctrl;
        logic [1:0]      src_a_sel;
        logic [1:0]      src_b_sel;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            valid;
    } ex_t;

    localparam ex_t EX_BUBBLE = '{
        reg_write: BUB_REGWRITE, mem_write: BUB_MEMWRITE, pc_branch: BUB_PCBRANCH,
        memtoreg:  BUB_MEMTOREG, jalr_ctrl: BUB_JALRCTRL, alu_op: BUB_ALUOP,
        str_ctrl:  BUB_STRCTRL,  src_a_sel: BUB_SRCSEL,   src_b_sel: BUB_SRCSEL,
        rd1: {XLEN{1'b0}}, rd2: {XLEN{1'b0}}, imm: {XLEN{1'b0}},
        pc:  {XLEN{1'b0}}, pc_plus4: {XLEN{1'b0}},
        rs1: REG_X0, rs2: REG_X0, rd: REG_X0, valid: 1'b0
    };

    ex_t  r_ex;
    ex_t  w_ex_d;
    logic w_lu_haz;
    logic w_stall_f;
    logic w_stall_d;
    logic w_flush_d;

    assign w_ex_d = '{
        reg_write: bus.RegWriteD, mem_write: bus.MemWriteD, pc_branch: bus.PCBranchD,
        memtoreg:  bus.MemtoRegD, jalr_ctrl: bus.JALRctrlD, alu_op: bus.ALUopD,
        str_ctrl:  bus.strCtrlD,  src_a_sel: bus.SrcASelD,  src_b_sel: bus.SrcBSelD,
        rd1: bus.RD1D, rd2: bus.RD2D, imm: bus.ImmExtD, pc: bus.PCD, pc_plus4: bus.PCPlus4D,
        rs1: bus.Rs1D, rs2: bus.Rs2D, rd: bus.RdD, valid: bus.validD
    };

    hazard_lu u_hazard_lu (
        .i_valid_e    (r_ex.valid),
        .i_memtoreg_e (r_ex.memtoreg),
        .i_rd_e       (r_ex.rd),
        .i_rs1_d      (bus.Rs1D),
        .i_rs2_d      (bus.Rs2D),
        .i_valid_d    (bus.validD),
        .i_flush_e    (bus.flush_e),
        .o_lu_haz     (w_lu_haz),
        .o_stall_f    (w_stall_f),
        .o_stall_d    (w_stall_d),
        .o_flush_d    (w_flush_d)
    );

    // Pipeline register: flush outranks the load-use bubble, both outrank capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex <= EX_BUBBLE;
        end else if (bus.flush_e) begin
            r_ex <= EX_BUBBLE;
        end else if (w_lu_haz) begin
            r_ex <= EX_BUBBLE;
        end else begin
            r_ex <= w_ex_d;
        end
    end

    assign bus.RegWriteE = r_ex.reg_write;
    assign bus.MemWriteE = r_ex.mem_write;
    assign bus.PCBranchE = r_ex.pc_branch;
    assign bus.MemtoRegE = r_ex.memtoreg;
    assign bus.JALRctrlE = r_ex.jalr_ctrl;
    assign bus.ALUopE    = r_ex.alu_op;
    assign bus.strCtrlE  = r_ex.str_ctrl;
    assign bus.SrcASelE  = r_ex.src_a_sel;
    assign bus.SrcBSelE  = r_ex.src_b_sel;
    assign bus.RD1E      = r_ex.rd1;
    assign bus.RD2E      = r_ex.rd2;
    assign bus.ImmExtE   = r_ex.imm;
    assign bus.PCE       = r_ex.pc;
    assign bus.PCPlus4E  = r_ex.pc_plus4;
    assign bus.Rs1E      = r_ex.rs1;
    assign bus.Rs2E      = r_ex.rs2;
    assign bus.RdE       = r_ex.rd;
    assign bus.validE    = r_ex.valid;
    assign bus.stall_f   = w_stall_f;
    assign bus.stall_d   = w_stall_d;
    assign bus.flush_d   = w_flush_d;

`ifdef IDEX_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Saturating event counters; w_lu_haz already excludes flush cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= {CNT_W{1'b0}};
            r_flush_cnt  <= {CNT_W{1'b0}};
        end else begin
            if (w_lu_haz && (r_bubble_cnt != CNT_MAX)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
            end else begin
                r_bubble_cnt <= r_bubble_cnt;
            end
            if (bus.flush_e && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (perf counters checked when
// IDEX_PERF_CNT_EN is defined).
module tb_id_ex_stage;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    id_ex_stage_if #(.XLEN(32)) bus ();

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] bcnt, fcnt;
    logic [3:0]  bcnt4, fcnt4;
    id_ex_stage_if #(.XLEN(32)) bus4 ();

    id_ex_stage #(.XLEN(32), .CNT_W(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus4),
        .bubble_cnt (bcnt4),
        .flush_cnt  (fcnt4)
    );
`endif

    id_ex_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef IDEX_PERF_CNT_EN
        ,
        .bubble_cnt (bcnt),
        .flush_cnt  (fcnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic mtr, input logic mw,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic vd, input logic fl);
        bus.RegWriteD = rw;   bus.MemtoRegD = mtr;  bus.MemWriteD = mw;
        bus.PCBranchD = 1'b0; bus.JALRctrlD = 1'b1; bus.ALUopD    = 4'd0;
        bus.strCtrlD  = 3'd0; bus.SrcASelD  = 2'd0; bus.SrcBSelD  = 2'd0;
        bus.RD1D = 32'd0; bus.RD2D = 32'd0; bus.ImmExtD = 32'd0;
        bus.PCD  = 32'd0; bus.PCPlus4D = 32'd0;
        bus.RdD = rd; bus.Rs1D = rs1; bus.Rs2D = rs2;
        bus.validD = vd; bus.flush_e = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [31:0] rnd;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
`ifdef IDEX_PERF_CNT_EN
        bus4.RegWriteD = 1'b1; bus4.MemtoRegD = 1'b1; bus4.MemWriteD = 1'b0;
        bus4.PCBranchD = 1'b0; bus4.JALRctrlD = 1'b1; bus4.ALUopD = 4'd0;
        bus4.strCtrlD = 3'd0; bus4.SrcASelD = 2'd0; bus4.SrcBSelD = 2'd0;
        bus4.RD1D = 32'd0; bus4.RD2D = 32'd0; bus4.ImmExtD = 32'd0;
        bus4.PCD = 32'd0; bus4.PCPlus4D = 32'd0;
        bus4.RdD = 5'd3; bus4.Rs1D = 5'd3; bus4.Rs2D = 5'd0;
        bus4.validD = 1'b0; bus4.flush_e = 1'b0;
`endif
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain capture of a random instruction
        rnd = $urandom;
        drive(1'b1, 1'b0, 1'b0, 5'd7, 5'd1, 5'd2, 1'b1, 1'b0);
        bus.JALRctrlD = 1'b0; bus.ALUopD = 4'h9; bus.RD1D = rnd;
        tick();
        chk("cap_regwrite", 64'(bus.RegWriteE), 64'd1);
        chk("cap_rd",       64'(bus.RdE),       64'd7);
        chk("cap_aluop",    64'(bus.ALUopE),    64'h9);
        chk("cap_rd1",      64'(bus.RD1E),      64'(rnd));
        chk("cap_jalr",     64'(bus.JALRctrlE), 64'd0);
        chk("cap_valid",    64'(bus.validE),    64'd1);

        // Mid-cycle async reset with random D inputs and flush_e high
        drive(1'b1, 1'b1, 1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1);
        bus.PCBranchD = 1'b1; bus.JALRctrlD = 1'b0; bus.ALUopD = 4'($urandom);
        bus.RD1D = $urandom; bus.RD2D = $urandom; bus.PCD = $urandom;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_regwrite", 64'(bus.RegWriteE), 64'd0);
        chk("rst_memwrite", 64'(bus.MemWriteE), 64'd0);
        chk("rst_pcbranch", 64'(bus.PCBranchE), 64'd0);
        chk("rst_memtoreg", 64'(bus.MemtoRegE), 64'd0);
        chk("rst_jalr",     64'(bus.JALRctrlE), 64'd1);
        chk("rst_valid",    64'(bus.validE),    64'd0);
        chk("rst_aluop",    64'(bus.ALUopE),    64'd0);
        chk("rst_rd1",      64'(bus.RD1E),      64'd0);
        chk("rst_pc",       64'(bus.PCE),       64'd0);
        chk("rst_rd",       64'(bus.RdE),       64'd0);
        chk("rst_stall_f",  64'(bus.stall_f),   64'd0);
        chk("rst_flush_d",  64'(bus.flush_d),   64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0);
        chk("rst_flush_d_lo", 64'(bus.flush_d), 64'd0);
        tick();
        chk("post_rst_regwrite", 64'(bus.RegWriteE), 64'd1);
        chk("post_rst_rd",       64'(bus.RdE),       64'd5);

        // Load-use: LW x3, then ADD x4,x3,x1
        drive(1'b1, 1'b1, 1'b0, 5'd3, 5'd2, 5'd0, 1'b1, 1'b0);
        #1 chk("lw_no_stall", 64'(bus.stall_f), 64'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 5'd4, 5'd3, 5'd1, 1'b1, 1'b0);
        #1;
        chk("lu_stall_f", 64'(bus.stall_f), 64'd1);
        chk("lu_stall_d", 64'(bus.stall_d), 64'd1);
        chk("lu_flush_d", 64'(bus.flush_d), 64'd0);
        tick();
        chk("lu_bub_valid",    64'(bus.validE),    64'd0);
        chk("lu_bub_regwrite", 64'(bus.RegWriteE), 64'd0);
        chk("lu_bub_jalr",     64'(bus.JALRctrlE), 64'd1);
        chk("lu_stall_f_end",  64'(bus.stall_f),   64'd0);
        tick();
        chk("lu_add_rd",    64'(bus.RdE),    64'd4);
        chk("lu_add_valid", 64'(bus.validE), 64'd1);
        chk("lu_add_rs1",   64'(bus.Rs1E),   64'd3);

        // Load into x0 never stalls a consumer of x0
        drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd2, 5'd0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 5'd6, 5'd0, 5'd0, 1'b1, 1'b0);
        #1 chk("x0_no_stall", 64'(bus.stall_f), 64'd0);
        tick();
        chk("x0_cons_rd",    64'(bus.RdE),    64'd6);
        chk("x0_cons_valid", 64'(bus.validE), 64'd1);

        // Flush wins over a simultaneous load-use hazard
        drive(1'b1, 1'b1, 1'b0, 5'd8, 5'd2, 5'd0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 5'd0, 5'd8, 5'd2, 1'b1, 1'b1);
        #1;
        chk("fl_stall_f", 64'(bus.stall_f), 64'd0);
        chk("fl_stall_d", 64'(bus.stall_d), 64'd0);
        chk("fl_flush_d", 64'(bus.flush_d), 64'd1);
        tick();
        chk("fl_bub_valid",    64'(bus.validE),    64'd0);
        chk("fl_bub_memwrite", 64'(bus.MemWriteE), 64'd0);
        chk("fl_bub_rs1",      64'(bus.Rs1E),      64'd0);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

`ifdef IDEX_PERF_CNT_EN
        // Counters: 3 load-use pairs and 2 flushes after a fresh reset
        rst_n = 1'b0;
        #1;
        chk("cnt_rst_bubble", 64'(bcnt), 64'd0);
        chk("cnt_rst_flush",  64'(fcnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus4.validD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 5'd3, 5'd2, 5'd0, 1'b1, 1'b0);
            tick();
            drive(1'b1, 1'b0, 1'b0, 5'd4, 5'd3, 5'd1, 1'b1, 1'b0);
            tick();
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
            tick();
            drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
            tick();
        end
        chk("cnt_bubble", 64'(bcnt), 64'd3);
        chk("cnt_flush",  64'(fcnt), 64'd2);
        // Self-dependent load on the 4-bit instance: one bubble every two cycles
        repeat (40) tick();
        chk("cnt4_bubble_sat", 64'(bcnt4), 64'd15);
        chk("cnt4_flush",      64'(fcnt4), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection. It sits between the decode stage (control decoder, register file read, immediate generator) and the execute stage. It captures decoded control and operands each cycle, inserts bubbles on load-use hazards, and squashes the decode-stage instruction on a taken branch or jump resolved in EX.

## Interface
- Parameters
  - XLEN, 32: datapath width.
  - CNT_W, 32: perf counter width (used only when IDEX_PERF_CNT_EN is defined).
- Ports (clock and reset first)
  - clk  in  1  rising-edge clock.
  - rst_n  in  1  reset, asynchronous assert, active-low.
  - RegWriteD, MemWriteD, PCBranchD, MemtoRegD, JALRctrlD  in  1 each  decoded control from ID.
  - ALUopD  in  4  ALU operation.
  - strCtrlD  in  3  load/store size control (funct3).
  - SrcASelD, SrcBSelD  in  2 each  ALU operand selects.
  - RD1D, RD2D, ImmExtD, PCD, PCPlus4D  in  XLEN each  operands and PCs.
  - Rs1D, Rs2D, RdD  in  5 each  register indices.
  - validD  in  1  ID holds a real instruction.
  - flush_e  in  1  taken branch/jump resolved in EX this cycle.
  - All `*D` fields above have matching `*E` outputs of the same width: the registered copies.
  - validE  out  1  EX holds a real instruction.
  - stall_f, stall_d  out  1 each  hold PC and IF/ID.
  - flush_d  out  1  clear IF/ID.

## Operation
- Hazard (combinational, from registered EX state): lu_haz = validE & MemtoRegE & (RdE != 0) & ((RdE == Rs1D) | (RdE == Rs2D)) & validD & ~flush_e.
  - Rs fields are compared for every opcode. This is conservative. Spurious stalls on LUI/JAL/AUIPC are permitted.
- stall_f = stall_d = lu_haz.
- flush_d = flush_e.
- Register update each posedge, in priority order:
  1. flush_e: load a bubble.
  2. lu_haz: load a bubble.
  3. Otherwise: capture all `*D` inputs, with validE <= validD.
- Bubble definition:
  - RegWriteE, MemWriteE, PCBranchE, MemtoRegE and validE are all 0.
  - JALRctrlE = 1 (non-JALR).
  - All other fields are 0.
- No stall input from downstream. EX/MEM/WB never stall in this pipeline.

## Timing
- Latency: 1 cycle from D inputs to E outputs.
- Reset: every output takes its bubble value asynchronously. Consequently stall_f = stall_d = 0, and flush_d follows flush_e.
- Load-use:
  - Cycle N: the load is in EX and the consumer is in ID, so lu_haz = 1.
  - Edge N→N+1: a bubble is loaded. The consumer is held in ID.
  - Cycle N+1: validE = 0, so lu_haz = 0.
  - Edge N+1→N+2: the consumer is captured.
  - Exactly one bubble per load-use pair.
- Back-to-back loads, where each feeds the next, produce one bubble per pair.
- flush_e together with a would-be hazard: flush wins, no stall, and ID is cleared via flush_d.
- RdE == 0 never stalls.
- Reset asserted mid-stall: outputs go to bubble immediately. After release, normal capture resumes on the first edge.

## Configuration
- IDEX_PERF_CNT_EN defined:
  - Adds output ports bubble_cnt and flush_cnt (CNT_W each).
  - Both reset to 0.
  - bubble_cnt increments on every edge where a bubble is loaded because of lu_haz.
  - flush_cnt increments on every edge where flush_e = 1.
  - Both saturate at all-ones.
- Not defined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared defines package holds:
  - opcode constants;
  - bubble values for control fields (including JALRctrl = 1);
  - the x0 index constant.
- One sub-module, hazard_lu, holds the combinational lu_haz, stall_f, stall_d and flush_d logic. The register bank and counters stay in id_ex_stage.

## Test plan
- Reset: drive rst_n = 0 mid-cycle with random D inputs.
  - Required: all E outputs are bubble values immediately, and JALRctrlE = 1.
  - Required after release, with RegWriteD = 1, RdD = 5, validD = 1: RegWriteE = 1 and RdE = 5 one edge later.
- Load-use: LW x3 into EX, then ADD x4,x3,x1 in ID.
  - Required: stall_f = stall_d = 1 for exactly 1 cycle, then validE = 0 and RegWriteE = 0.
  - Required: the ADD appears in EX (RdE = 4) the following edge.
- x0 load: LW x0 in EX, consumer reading x0.
  - Required: no stall, and the consumer is captured the next edge.
- Flush with hazard: flush_e = 1 while the load-use condition is also present in the inputs.
  - Required: stall_f = 0, flush_d = 1, and the next E state is a bubble with MemWriteE = 0.
- Perf counters (IDEX_PERF_CNT_EN): 3 load-use pairs and 2 flushes.
  - Required: bubble_cnt = 3 and flush_cnt = 2.
  - Preload CNT_W = 4 and apply 20 bubbles. Required: bubble_cnt = 15.
